// File: rtl/trace_buffer.sv
// Retire-trace FIFO: first-word-fall-through buffer of retired-instruction records with
// drop accounting and an exit/drain/done sequence. Optional macro TRACE_WB_FILTER_EN keeps
// only register-writing records.
module trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DROPW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_wb_en,
  input  logic [4:0]       in_wb_addr,
  input  logic [31:0]      in_wb_data,
  input  logic             in_exit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_wb_en,
  output logic [4:0]       out_wb_addr,
  output logic [31:0]      out_wb_data,
  output logic             overflow,
  output logic [DROPW-1:0] drop_cnt,
  output logic             done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          head;
  state_e        state_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, done_q;
  logic [DROPW-1:0] drop_cnt_q;
  logic          rec_ok, accept, full, push, pop, drop;

`ifdef TRACE_WB_FILTER_EN
  assign rec_ok = in_wb_en;
`else
  assign rec_ok = 1'b1;
`endif

  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0) && (state_q != StDone);
  assign pop       = out_valid && out_ready;
  assign accept    = in_valid && (state_q == StRun) && rec_ok;
  // A full FIFO still takes the record when the head leaves on the same edge.
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{pc: in_pc, inst: in_inst, wb_en: in_wb_en,
                         wb_addr: in_wb_addr, wb_data: in_wb_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROPW'(1);
      end
      case (state_q)
        StRun: begin
          if (in_exit) state_q <= StDrain;
        end
        StDrain: begin
          if (count_d == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StDone;
      endcase
    end
  end

  // Fields read as zero whenever no record is presented (covers reset and unwritten storage).
  assign head        = out_valid ? mem[rd_ptr_q] : '0;
  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_wb_en   = head.wb_en;
  assign out_wb_addr = head.wb_addr;
  assign out_wb_data = head.wb_data;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  assign done        = done_q;

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter: DEPTH, 16, number of retire-record entries; power of two, 2..256.
REQ-002 Parameter: DROPW, 16, width of the dropped-record counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  core retired one instruction this cycle.
REQ-006 in_pc  input  32  pc_reg of retired instruction.
REQ-007 in_inst  input  32  retired instruction word.
REQ-008 in_wb_en  input  1  retired instruction writes a register.
REQ-009 in_wb_addr  input  5  destination register index.
REQ-010 in_wb_data  input  32  value written back.
REQ-011 in_exit  input  1  core exit indication.
REQ-012 out_valid  output  1  head record available.
REQ-013 out_ready  input  1  consumer accepts head record.
REQ-014 out_pc, out_inst, out_wb_data  output  32 each  head record fields.
REQ-015 out_wb_addr  output  5  head record field; out_wb_en  output  1  head record field.
REQ-016 overflow  output  1  sticky: at least one record dropped.
REQ-017 drop_cnt  output  DROPW  records dropped since reset.
REQ-018 done  output  1  exit seen and buffer fully drained.

Function
REQ-019 Storage: circular FIFO of DEPTH records (pc, inst, wb_en, wb_addr, wb_data = 102 bits); write/read pointers wrap modulo DEPTH; occupancy count 0..DEPTH.
REQ-020 Push: in_valid=1 in state RUN and record passes filter (REQ-031) -> record written at rising edge.
REQ-021 Latency: record pushed into empty FIFO at edge N -> out_valid=1 and fields valid after edge N (first-word-fall-through, no combinational in-to-out path).
REQ-022 Pop: out_valid=1 and out_ready=1 at an edge -> head advances; out_* hold stable while out_valid=1 and out_ready=0.
REQ-023 Full, push without pop: record dropped, overflow set, drop_cnt incremented, saturating at all-ones.
REQ-024 Full, push with pop same edge: push accepted, occupancy stays DEPTH, no drop.
REQ-025 Empty, push and out_ready=1 same edge: no pop (out_valid was 0); occupancy becomes 1.
REQ-026 FSM states: RUN, DRAIN, DONE.
REQ-027 RUN -> DRAIN when in_exit=1; a record presented with in_valid in that same cycle is still pushed (subject to REQ-023/024).
REQ-028 DRAIN: in_valid ignored (not pushed, not counted as drop); pops continue; DRAIN -> DONE when occupancy is 0 after the edge (exit with empty FIFO: DRAIN lasts one cycle).
REQ-029 DONE: done=1, out_valid=0, in_valid/in_exit ignored; leaves only on reset.
REQ-030 in_exit asserted in DRAIN or DONE: no effect.

Reset
REQ-032 rst=1 asynchronously: state RUN, pointers and occupancy 0, out_valid 0, out_* fields 0, overflow 0, drop_cnt 0, done 0.
REQ-033 Reset mid-operation discards all stored records; first push after rst deassertion behaves as into empty FIFO.

Configuration
REQ-031 Macro TRACE_WB_FILTER_EN: defined -> only records with in_wb_en=1 are pushed, others silently ignored (not drops); undefined -> every in_valid record pushed.

Verification
REQ-034 Reset, push 3 records (pc 0x0,0x4,0x8), out_ready=1 -> out_pc 0x0,0x4,0x8 in order, one per cycle, each appearing one edge after its push.
REQ-035 DEPTH=16, out_ready=0, push 18 records -> occupancy 16, overflow=1, drop_cnt=2; drain yields first 16 pcs in order.
REQ-036 Full FIFO, push pc 0x100 with out_ready=1 same edge -> no drop, drop_cnt unchanged, 0x100 read last.
REQ-037 Push 2 records, in_exit=1 with in_valid pc 0x20, then in_valid pulses -> only 3 records drained, done=1 one edge after last pop, later in_valid ignored.
REQ-038 Assert rst with 5 records stored -> all outputs 0 immediately; next push pc 0x40 appears as sole out_valid record.
REQ-039 TRACE_WB_FILTER_EN defined, push in_wb_en sequence 1,0,1 -> 2 records out, drop_cnt=0; undefined -> 3 records out.
